// File: rtl/svi_array_arbiter.sv
// svi_array_arbiter
// Round-robin arbiter sharing one registered output channel among N_REQ requesters.
// A grant won in arbitration is locked to its owner until the beat flagged last,
// so multi-beat bursts are never interleaved. The winning beat is registered onto
// the shared channel and the output register reloads in the same cycle its
// current beat is consumed, giving one beat per cycle.
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous active-low reset
//   i_req_valid  per-requester beat valid
//   i_req_data   requester k data on [k*DW +: DW]
//   i_req_last   per-requester last-beat-of-burst flag
//   o_req_ready  per-requester accept, at most one bit high
//   o_valid      shared channel beat valid
//   o_data       shared channel data
//   o_last       shared channel last flag
//   o_gnt_id     index of the requester that sourced the current beat
//   i_ready      downstream accept
module svi_array_arbiter #(
   parameter int unsigned  N_REQ = 4,
   parameter int unsigned  DW    = 8,
   localparam int unsigned IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [N_REQ-1:0]    i_req_valid,
   input  logic [N_REQ*DW-1:0] i_req_data,
   input  logic [N_REQ-1:0]    i_req_last,
   output logic [N_REQ-1:0]    o_req_ready,
   output logic                o_valid,
   output logic [DW-1:0]       o_data,
   output logic                o_last,
   output logic [IW-1:0]       o_gnt_id,
   input  logic                i_ready
);

   typedef enum logic [0:0] {StArb, StLock} state_e;

   state_e        state_q, state_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] owner_q, owner_d;
   logic          o_valid_q, o_valid_d;
   logic [DW-1:0] o_data_q, o_data_d;
   logic          o_last_q, o_last_d;
   logic [IW-1:0] o_gnt_id_q, o_gnt_id_d;

   logic          hi_found, lo_found, lock_valid;
   logic [IW-1:0] hi_idx, lo_idx;
   logic          cand_found;
   logic [IW-1:0] cand_idx;
   logic [DW-1:0] cand_data;
   logic          cand_last;
   logic          load_en;

   // Cyclic search from ptr: the first valid at or above ptr wins, otherwise
   // the lowest valid index overall (the wrapped part of the search).
   always_comb begin
      hi_found   = 1'b0;
      lo_found   = 1'b0;
      hi_idx     = '0;
      lo_idx     = '0;
      lock_valid = 1'b0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         if (i_req_valid[i]) begin
            if (!lo_found) begin
               lo_found = 1'b1;
               lo_idx   = IW'(i);
            end
            if (!hi_found && (IW'(i) >= ptr_q)) begin
               hi_found = 1'b1;
               hi_idx   = IW'(i);
            end
         end
         if (IW'(i) == owner_q) begin
            lock_valid = i_req_valid[i];
         end
      end
   end

   always_comb begin
      if (state_q == StLock) begin
         cand_found = lock_valid;
         cand_idx   = owner_q;
      end else begin
         cand_found = hi_found | lo_found;
         cand_idx   = hi_found ? hi_idx : lo_idx;
      end
   end

   always_comb begin
      cand_data = '0;
      cand_last = 1'b0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         if (IW'(i) == cand_idx) begin
            cand_data = i_req_data[i*DW +: DW];
            cand_last = i_req_last[i];
         end
      end
   end

   assign load_en = cand_found && (!o_valid_q || i_ready);

   // FSM state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= StArb;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StArb: begin
            if (load_en && !cand_last) begin
               state_d = StLock;
            end
         end
         StLock: begin
            if (load_en && cand_last) begin
               state_d = StArb;
            end
         end
         default: state_d = StArb;
      endcase
   end

   // FSM outputs: ready is gated by reset so nothing is accepted while held.
   always_comb begin
      o_req_ready = '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         o_req_ready[i] = i_rst_n && load_en && (cand_idx == IW'(i));
      end
   end

   // Datapath next state
   always_comb begin
      ptr_d      = ptr_q;
      owner_d    = owner_q;
      o_valid_d  = o_valid_q;
      o_data_d   = o_data_q;
      o_last_d   = o_last_q;
      o_gnt_id_d = o_gnt_id_q;
      if (load_en) begin
         o_valid_d  = 1'b1;
         o_data_d   = cand_data;
         o_last_d   = cand_last;
         o_gnt_id_d = cand_idx;
         if (state_q == StArb) begin
            ptr_d = (cand_idx == IW'(N_REQ - 1)) ? '0 : cand_idx + IW'(1);
            if (!cand_last) begin
               owner_d = cand_idx;
            end
         end
      end else if (i_ready) begin
         o_valid_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ptr_q      <= '0;
         owner_q    <= '0;
         o_valid_q  <= 1'b0;
         o_data_q   <= '0;
         o_last_q   <= 1'b0;
         o_gnt_id_q <= '0;
      end else begin
         ptr_q      <= ptr_d;
         owner_q    <= owner_d;
         o_valid_q  <= o_valid_d;
         o_data_q   <= o_data_d;
         o_last_q   <= o_last_d;
         o_gnt_id_q <= o_gnt_id_d;
      end
   end

   assign o_valid  = o_valid_q;
   assign o_data   = o_data_q;
   assign o_last   = o_last_q;
   assign o_gnt_id = o_gnt_id_q;

endmodule

// File: tb/tb_svi_array_arbiter.sv
// Testbench for svi_array_arbiter (N_REQ=4, DW=8): directed scenarios with literal
// expectations followed by randomized traffic, all checked every cycle against a
// behavioural round-robin/burst-lock model.
module tb_svi_array_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int IW = 2;

   logic          clk;
   logic          rst_n;
   logic [N-1:0]  req_valid;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]  req_last;
   logic [N-1:0]  req_ready;
   logic          o_valid;
   logic [DW-1:0] o_data;
   logic          o_last;
   logic [IW-1:0] o_gnt_id;
   logic          i_ready;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model: lock flag, owner, pointer and the registered output beat.
   bit m_lock;
   int m_owner;
   int m_ptr;
   bit m_ov;
   bit m_ol;
   int m_od;
   int m_oid;

   svi_array_arbiter #(
      .N_REQ(N),
      .DW   (DW)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_req_valid(req_valid),
      .i_req_data (req_data),
      .i_req_last (req_last),
      .o_req_ready(req_ready),
      .o_valid    (o_valid),
      .o_data     (o_data),
      .o_last     (o_last),
      .o_gnt_id   (o_gnt_id),
      .i_ready    (i_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Compare process: inputs change only just after the rising edge, so on the
   // falling edge they are stable for the upcoming edge.
   always @(negedge clk) begin : compare
      int cand;
      int k;
      bit can_load;
      logic [N-1:0] exp_rdy;
      cand    = -1;
      exp_rdy = '0;
      if (!rst_n) begin
         m_lock  = 1'b0;
         m_owner = 0;
         m_ptr   = 0;
         m_ov    = 1'b0;
         m_ol    = 1'b0;
         m_od    = 0;
         m_oid   = 0;
      end else begin
         if (m_lock) begin
            if (((req_valid >> m_owner) & 4'd1) != 4'd0) cand = m_owner;
         end else begin
            for (int j = 0; j < N; j++) begin
               k = (m_ptr + j) % N;
               if (cand < 0 && (((req_valid >> k) & 4'd1) != 4'd0)) cand = k;
            end
         end
         can_load = !m_ov || i_ready;
         if (cand >= 0 && can_load) exp_rdy = N'(1 << cand);
      end
      chk("ready", 32'(req_ready), 32'(exp_rdy));
      chk("o_valid", 32'(o_valid), 32'(m_ov));
      chk("o_data", 32'(o_data), 32'(m_od));
      chk("o_last", 32'(o_last), 32'(m_ol));
      chk("o_gnt_id", 32'(o_gnt_id), 32'(m_oid));
      if (rst_n) begin
         if (exp_rdy != '0) begin
            m_ov  = 1'b1;
            m_od  = int'((req_data >> (cand * DW)) & 32'hFF);
            m_ol  = (((req_last >> cand) & 4'd1) != 4'd0);
            m_oid = cand;
            if (!m_lock) begin
               m_ptr = (cand + 1) % N;
               if (!m_ol) begin
                  m_lock  = 1'b1;
                  m_owner = cand;
               end
            end else if (m_ol) begin
               m_lock = 1'b0;
            end
         end else if (i_ready) begin
            m_ov = 1'b0;
         end
      end
   end

   initial begin
      clk       = 1'b0;
      rst_n     = 1'b1;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      i_ready   = 1'b0;
      #1;
      // Reset with every requester asking
      rst_n     = 1'b0;
      req_valid = 4'b1111;
      req_last  = 4'b1111;
      i_ready   = 1'b1;
      tick();
      tick();
      chk("rst_o_valid", 32'(o_valid), 32'd0);
      chk("rst_o_data", 32'(o_data), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);

      // Round-robin on single beats
      req_data = 32'h13121110;
      rst_n    = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("rr_valid", 32'(o_valid), 32'd1);
         chk("rr_id", 32'(o_gnt_id), 32'(c % 4));
         chk("rr_data", 32'(o_data), 32'(16 + (c % 4)));
      end

      // Burst lock on requester 2 while 0 and 1 wait
      req_valid = '0;
      tick();
      tick();
      req_valid        = 4'b0100;
      req_last         = 4'b0000;
      req_data[23:16]  = 8'hA0;
      tick();
      chk("burst_id0", 32'(o_gnt_id), 32'd2);
      chk("burst_d0", 32'(o_data), 32'hA0);
      req_valid        = 4'b0111;
      req_data[23:16]  = 8'hA1;
      tick();
      chk("burst_id1", 32'(o_gnt_id), 32'd2);
      chk("burst_d1", 32'(o_data), 32'hA1);
      req_data[23:16]  = 8'hA2;
      req_last         = 4'b1111;
      tick();
      chk("burst_id2", 32'(o_gnt_id), 32'd2);
      chk("burst_d2", 32'(o_data), 32'hA2);
      chk("burst_last", 32'(o_last), 32'd1);
      req_valid = 4'b0011;
      tick();
      chk("after_burst_id", 32'(o_gnt_id), 32'd0);
      chk("after_burst_d", 32'(o_data), 32'h10);

      // Backpressure holds the beat and blocks all requesters
      req_valid      = 4'b0001;
      req_data[7:0]  = 8'h5C;
      tick();
      chk("bp_load", 32'(o_data), 32'h5C);
      req_valid      = 4'b0010;
      req_data[15:8] = 8'h77;
      i_ready        = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("bp_ready", 32'(req_ready), 32'd0);
         tick();
         chk("bp_hold", 32'(o_data), 32'h5C);
         chk("bp_valid", 32'(o_valid), 32'd1);
      end
      i_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(req_ready), 32'b0010);
      tick();
      chk("bp_next_d", 32'(o_data), 32'h77);
      chk("bp_next_id", 32'(o_gnt_id), 32'd1);

      // Owner stall: requester 1 locks, then drops valid for 3 cycles
      req_valid      = 4'b0010;
      req_data[15:8] = 8'h31;
      req_last       = 4'b1101;
      tick();
      chk("stall_id", 32'(o_gnt_id), 32'd1);
      chk("stall_last", 32'(o_last), 32'd0);
      req_valid = 4'b1000;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("stall_ready", 32'(req_ready), 32'd0);
         tick();
         chk("stall_bubble", 32'(o_valid), 32'd0);
      end
      req_valid      = 4'b1010;
      req_data[15:8] = 8'h32;
      req_last       = 4'b1111;
      #1;
      chk("stall_resume_ready", 32'(req_ready), 32'b0010);
      tick();
      chk("stall_resume_id", 32'(o_gnt_id), 32'd1);
      chk("stall_resume_d", 32'(o_data), 32'h32);

      // Asynchronous reset during a lock on requester 3
      req_valid       = 4'b1000;
      req_data[31:24] = 8'hD0;
      req_last        = 4'b0111;
      tick();
      chk("mid_lock_id", 32'(o_gnt_id), 32'd3);
      req_data[31:24] = 8'hD1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(o_valid), 32'd0);
      chk("mid_rst_ready", 32'(req_ready), 32'd0);
      tick();
      rst_n          = 1'b1;
      req_valid      = 4'b1001;
      req_last       = 4'b1111;
      req_data[7:0]  = 8'hE0;
      tick();
      chk("post_rst_id", 32'(o_gnt_id), 32'd0);
      chk("post_rst_d", 32'(o_data), 32'hE0);

      // Randomized traffic, backpressure and occasional reset
      for (int c = 0; c < 3000; c++) begin
         req_valid = 4'($urandom);
         req_last  = 4'($urandom);
         req_data  = 32'($urandom);
         i_ready   = ($urandom_range(0, 3) != 0);
         rst_n     = ($urandom_range(0, 199) != 0);
         tick();
      end
      rst_n     = 1'b1;
      req_valid = '0;
      i_ready   = 1'b1;
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
